// File: rtl/apple_feeder.sv
// Apple feeder: holds one apple on the grid, detects a head hit, pulses addLength, bumps score and relocates the apple via LFSR.
// Latency: hit seen 2 cycles after the head moves onto the apple; no backpressure, RELOC retries a new candidate every cycle.
module apple_feeder #(
  parameter int          MAXX      = 40,
  parameter int          MAXY      = 30,
  parameter int          MAX_LEN   = 16,
  parameter int          ADD_PULSE = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          INIT_X    = 20,
  parameter int          INIT_Y    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] gameStatus,
  input  logic [5:0] headX,
  input  logic [5:0] headY,
  input  logic [6:0] bodyNum,
  input  logic [9:0] xPos,
  input  logic [9:0] yPos,
  output logic       addLength,
  output logic [5:0] appleX,
  output logic [5:0] appleY,
  output logic       apple,
  output logic [7:0] score
);

  typedef enum logic [1:0] {IDLE, PLACED, EAT, RELOC} state_t;

  localparam logic [1:0] PLAY = 2'b10;
  localparam int         CW   = $clog2(ADD_PULSE + 1);

  state_t        state_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [5:0]    head_x_q;
  logic [5:0]    head_y_q;
  logic [5:0]    apple_x_q;
  logic [5:0]    apple_y_q;
  logic [7:0]    score_q;
  logic [7:0]    score_d;
  logic          add_q;
  logic [CW-1:0] cnt_q;

  logic [5:0]    cand_x;
  logic [5:0]    cand_y;
  logic          cand_ok;
  logic          hit;
  logic          play;

  assign play    = (gameStatus == PLAY);
  assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

  // Hit uses the registered head so the compare path starts at a flop.
  assign hit     = (head_x_q == apple_x_q) && (head_y_q == apple_y_q);

  assign cand_x  = lfsr_q[5:0];
  assign cand_y  = lfsr_q[11:6];
  assign cand_ok = (cand_x >= 6'd1) && (cand_x <= 6'(MAXX - 2)) &&
                   (cand_y >= 6'd1) && (cand_y <= 6'(MAXY - 2)) &&
                   !((cand_x == head_x_q) && (cand_y == head_y_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      head_x_q  <= '0;
      head_y_q  <= '0;
      apple_x_q <= 6'(INIT_X);
      apple_y_q <= 6'(INIT_Y);
      score_q   <= '0;
      add_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      head_x_q <= headX;
      head_y_q <= headY;
      if (!play) begin
        // Abandoning a RELOC keeps the old apple; an EAT keeps its score bump.
        state_q <= IDLE;
        add_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= PLACED;
          PLACED: begin
            if (hit) begin
              state_q <= EAT;
              cnt_q   <= '0;
              score_q <= score_d;
              add_q   <= (bodyNum < 7'(MAX_LEN));
            end
          end
          EAT: begin
            // The RELOC cycle that follows guarantees a low gap before the next pulse.
            if (cnt_q == CW'(ADD_PULSE - 1)) begin
              state_q <= RELOC;
              add_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RELOC: begin
            if (cand_ok) begin
              apple_x_q <= cand_x;
              apple_y_q <= cand_y;
              state_q   <= PLACED;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign addLength = add_q;
  assign appleX    = apple_x_q;
  assign appleY    = apple_y_q;
  assign score     = score_q;

  assign apple = (xPos < 10'd640) && (yPos < 10'd480) &&
                 (xPos[9:4] == apple_x_q) && (yPos[9:4] == apple_y_q) &&
                 (state_q != RELOC);

endmodule

// File: tb/tb_apple_feeder.sv
// Directed bench for apple_feeder: scoreboard queues of expected addLength/score values checked as the DUT responds.
module tb_apple_feeder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gameStatus;
  logic [5:0] headX;
  logic [5:0] headY;
  logic [6:0] bodyNum;
  logic [9:0] xPos;
  logic [9:0] yPos;
  logic       addLength;
  logic [5:0] appleX;
  logic [5:0] appleY;
  logic       apple;
  logic [7:0] score;

  apple_feeder dut (
    .clk(clk), .rst_n(rst_n), .gameStatus(gameStatus), .headX(headX), .headY(headY),
    .bodyNum(bodyNum), .xPos(xPos), .yPos(yPos), .addLength(addLength),
    .appleX(appleX), .appleY(appleY), .apple(apple), .score(score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_add_q[$];
  int exp_score_q[$];
  int exp_score;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_score();
    exp_score = (exp_score >= 255) ? 255 : exp_score + 1;
  endtask

  task automatic drain_add(input string tag);
    while (exp_add_q.size() > 0) begin
      tick();
      check(tag, addLength, exp_add_q.pop_front());
    end
  endtask

  task automatic wait_reloc(input logic [5:0] ox, input logic [5:0] oy);
    int n = 0;
    while ((appleX == ox) && (appleY == oy) && (n < 400)) begin
      tick();
      n++;
    end
    check("reloc_done", ((appleX != ox) || (appleY != oy)), 1);
  endtask

  task automatic check_playable(input string tag, input logic [5:0] hx, input logic [5:0] hy);
    logic ok;
    ok = (appleX >= 1) && (appleX <= 38) && (appleY >= 1) && (appleY <= 28) &&
         !((appleX == hx) && (appleY == hy));
    check(tag, ok, 1);
  endtask

  task automatic eat_once(input string tag);
    logic [5:0] ox;
    logic [5:0] oy;
    ox = appleX;
    oy = appleY;
    headX = ox;
    headY = oy;
    bump_score();
    exp_score_q.push_back(exp_score);
    wait_reloc(ox, oy);
    check(tag, score, exp_score_q.pop_front());
  endtask

  initial begin
    logic [5:0] sx;
    logic [5:0] sy;
    logic       stable;
    rst_n = 1'b1; gameStatus = 2'b00; headX = 6'd0; headY = 6'd0;
    bodyNum = 7'd0; xPos = 10'd0; yPos = 10'd0; exp_score = 0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_add", addLength, 0);
    check("rst_ax", appleX, 20);
    check("rst_ay", appleY, 15);
    check("rst_score", score, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Scan: apple cell (20,15) covers x 320..335, y 240..255.
    for (int i = 0; i < 16; i++) begin
      xPos = 10'(320 + i); yPos = 10'(240 + i); #1;
      check("scan_in", apple, 1);
    end
    xPos = 10'd336; yPos = 10'd248; #1; check("scan_x336", apple, 0);
    xPos = 10'd700; #1; check("scan_x700", apple, 0);
    xPos = 10'd320; yPos = 10'd256; #1; check("scan_y256", apple, 0);

    // Eat the initial apple.
    gameStatus = 2'b10;
    tick();
    headX = 6'd20; headY = 6'd15;
    exp_add_q = '{0, 1, 1, 1, 1, 0};
    bump_score();
    drain_add("s1_add");
    check("s1_score", score, exp_score);
    wait_reloc(6'd20, 6'd15);
    check_playable("s2_newpos", 6'd20, 6'd15);
    headX = 6'd0; headY = 6'd0;
    sx = appleX; sy = appleY; stable = 1'b1;
    repeat (20) begin
      tick();
      if ((appleX != sx) || (appleY != sy)) stable = 1'b0;
    end
    check("s2_stable", stable, 1);
    check("s2_score", score, exp_score);

    // Full body: no growth pulse, but still scores and relocates.
    bodyNum = 7'd16;
    sx = appleX; sy = appleY;
    headX = sx; headY = sy;
    exp_add_q = '{0, 0, 0, 0, 0, 0};
    bump_score();
    drain_add("s3_add");
    check("s3_score", score, exp_score);
    wait_reloc(sx, sy);
    check_playable("s3_newpos", sx, sy);

    // Drop out of PLAY during the second EAT cycle.
    bodyNum = 7'd0;
    sx = appleX; sy = appleY;
    headX = sx; headY = sy;
    bump_score();
    tick(); check("s4_pre", addLength, 0);
    tick(); check("s4_eat1", addLength, 1);
    tick(); check("s4_eat2", addLength, 1);
    gameStatus = 2'b01;
    tick(); check("s4_drop", addLength, 0);
    check("s4_score", score, exp_score);
    stable = 1'b1;
    repeat (8) begin
      tick();
      if ((addLength != 1'b0) || (appleX != sx) || (appleY != sy)) stable = 1'b0;
    end
    check("s4_idle_hold", stable, 1);
    check("s4_score_hold", score, exp_score);
    // Resume with the head still on the apple: it is eaten again.
    gameStatus = 2'b10;
    exp_add_q = '{0, 1, 1, 1, 1, 0};
    bump_score();
    drain_add("s4_reeat_add");
    check("s4_reeat_score", score, exp_score);
    wait_reloc(sx, sy);

    // Saturate the score, then one more eat must hold 255.
    while (exp_score < 255) eat_once("sat_score");
    eat_once("sat_hold");

    // Reset in the middle of an EAT.
    sx = appleX; sy = appleY;
    headX = sx; headY = sy;
    tick(); tick(); tick();
    check("s6_in_eat", addLength, 1);
    rst_n = 1'b0;
    #1;
    check("s6_rst_add", addLength, 0);
    check("s6_rst_ax", appleX, 20);
    check("s6_rst_ay", appleY, 15);
    check("s6_rst_score", score, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
